pe_result_collector: RTL and testbench

- Downstream of pe_array: captures pe_array data_out once the fixed pipeline latency has elapsed after each instruction issue, tags it, and buffers it in a FIFO.
- Presents results to the writeback/memory side over a valid/ready handshake.
- Issues credit-based backpressure (issue_ready) to the controller, so no result is ever dropped by the pipeline.

---
 rtl/pe_result_collector.sv | 159 +++++++++++++++
 tb/tb_pe_result_collector.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_collector.sv
// -----------------------------------------------------------------------------
// pe_result_collector
//
// Sits behind pe_array. Each accepted instruction carries a writeback tag down
// a LAT-stage delay line that matches the pe_array pipeline. When the tag
// reaches the last stage, pe_array data_out is valid on that same edge and
// {tag, data} is pushed into a DEPTH-entry FIFO. The FIFO head is presented
// to the writeback side over valid/ready.
//
// The controller sees credit-based backpressure: an issue is accepted only
// while buffered entries plus in-flight writeback issues are below DEPTH.
// A result therefore always has a FIFO slot waiting when it leaves the
// pipeline.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   issue_valid  controller presents an instruction this cycle
//   issue_ready  collector has credit for another issue
//   issue_wb     1: result is written back, 0: result is discarded
//   issue_tag    writeback address travelling with the instruction
//   pe_data      pe_array data_out
//   out_valid    head FIFO entry valid
//   out_ready    consumer takes the head entry
//   out_tag      head entry tag
//   out_data     head entry data
//   inflight     writeback issues still inside the delay line
//   busy         anything in flight or buffered
//   ovf_err      sticky: a push arrived while the FIFO was full
// -----------------------------------------------------------------------------
module pe_result_collector #(
    parameter int WIDTH   = 24,
    parameter int NUM     = 4,
    parameter int OUT_NUM = 2,
    parameter int LAT     = 6,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    issue_valid,
    output logic                                    issue_ready,
    input  logic                                    issue_wb,
    input  logic [TAG_W-1:0]                        issue_tag,
    input  logic [0:NUM-1][0:OUT_NUM-1][WIDTH-1:0]  pe_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [TAG_W-1:0]                        out_tag,
    output logic [0:NUM-1][0:OUT_NUM-1][WIDTH-1:0]  out_data,
    output logic [3:0]                              inflight,
    output logic                                    busy,
    output logic                                    ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [0:NUM-1][0:OUT_NUM-1][WIDTH-1:0] data_t;

    // Delay line: valid bit plus tag per stage.
    logic [LAT-1:0]   dl_v;
    logic [TAG_W-1:0] dl_tag [LAT];

    // FIFO storage and bookkeeping.
    data_t            mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       inflight_q;

    logic fire;
    logic wb_fire;
    logic push;
    logic push_ok;
    logic pop;
    logic full;

    assign fire    = issue_valid & issue_ready;
    assign wb_fire = fire & issue_wb;
    assign push    = dl_v[LAT-1];
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push & ~full;
    assign pop     = out_valid & out_ready;

    // Credit is taken from registered state only, so issue_ready never loops
    // back through issue_valid. A wb issue takes its credit while in the delay
    // line and keeps it once it lands in the FIFO; a pop returns it.
    assign issue_ready = (32'(count) + 32'(inflight_q)) < 32'(DEPTH);

    // Head outputs come straight from FIFO registers; gated so that an empty
    // FIFO shows zeros rather than stale storage.
    assign out_valid = (count != '0);
    assign out_tag   = out_valid ? mem_tag[rd_ptr]  : '0;
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;

    assign inflight = inflight_q;
    assign busy     = (inflight_q != 4'd0) | out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_tag[i] <= '0;
            end
        end else begin
            // Non-wb issues still occupy a pipeline slot but travel with v=0.
            dl_v[0]   <= wb_fire;
            dl_tag[0] <= issue_tag;
            for (int i = 1; i < LAT; i++) begin
                dl_v[i]   <= dl_v[i-1];
                dl_tag[i] <= dl_tag[i-1];
            end
        end
    end

    // Counts every v bit leaving the line, including a dropped push, so it
    // always equals the popcount of dl_v.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 4'd0;
        end else begin
            inflight_q <= inflight_q + 4'(wb_fire) - 4'(push);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push & full) begin
                ovf_err <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; out_valid gating hides its contents when empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= pe_data;
            mem_tag[wr_ptr]  <= dl_tag[LAT-1];
        end
    end

endmodule

// File: tb/tb_pe_result_collector.sv
module tb_pe_result_collector;

    localparam int WIDTH   = 24;
    localparam int NUM     = 4;
    localparam int OUT_NUM = 2;
    localparam int LAT     = 6;
    localparam int DEPTH   = 8;
    localparam int TAG_W   = 8;

    typedef logic [0:NUM-1][0:OUT_NUM-1][WIDTH-1:0] data_t;
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        data_t            data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_wb = 1'b0;
    logic [TAG_W-1:0] issue_tag = '0;
    logic             out_ready = 1'b0;
    data_t            pe_data;
    logic             issue_ready;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    data_t            out_data;
    logic [3:0]       inflight;
    logic             busy;
    logic             ovf_err;

    int tests_run = 0;
    int fails     = 0;
    int n_out     = 0;
    int cyc       = 0;

    exp_t q[$];

    pe_result_collector #(
        .WIDTH(WIDTH), .NUM(NUM), .OUT_NUM(OUT_NUM),
        .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_wb(issue_wb), .issue_tag(issue_tag),
        .pe_data(pe_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_data(out_data),
        .inflight(inflight), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // cyc is the index of the next rising edge; pe_data sampled at that edge
    // is gen(cyc).
    always @(posedge clk) cyc <= cyc + 1;

    function automatic data_t gen(input int c);
        data_t d;
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < OUT_NUM; j++)
                d[i][j] = WIDTH'(c * 97 + i * 13 + j * 5 + 134);
        return d;
    endfunction

    assign pe_data = gen(cyc);

    // Scoreboard: record wb issues that will fire, compare on every pop.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (issue_valid && issue_ready && issue_wb) begin
                e.tag  = issue_tag;
                e.data = gen(cyc + LAT);
                q.push_back(e);
            end
            if (out_valid && out_ready) begin
                n_out++;
                tests_run++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got tag %0h, expected no output", out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_tag !== e.tag || out_data !== e.data) begin
                        fails++;
                        $display("FAIL sb_result: got tag %0h data %0h, expected tag %0h data %0h",
                                 out_tag, out_data, e.tag, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wb, input logic [TAG_W-1:0] tag);
        issue_valid = 1'b1;
        issue_wb    = wb;
        issue_tag   = tag;
        step();
        issue_valid = 1'b0;
        issue_wb    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #23;
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
        tests_run++;
        if (inflight !== 4'd0) begin fails++; $display("FAIL reset_inflight: got %0d, expected 0", inflight); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        tests_run++;
        if (ovf_err !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b, expected 0", ovf_err); end
        tests_run++;
        if (out_tag !== '0 || out_data !== '0) begin
            fails++; $display("FAIL reset_out_zero: got tag %0h data %0h, expected 0", out_tag, out_data);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready: got %0b, expected 1", issue_ready); end
        step();
    endtask

    task automatic test_single();
        int   c0;
        logic early;
        c0 = cyc;
        issue(1'b1, 8'h11);
        @(negedge clk);
        tests_run++;
        if (inflight !== 4'd1) begin fails++; $display("FAIL single_inflight: got %0d, expected 1", inflight); end
        early = out_valid;
        for (int k = 2; k <= LAT; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) early = 1'b1;
        end
        tests_run++;
        if (early !== 1'b0) begin fails++; $display("FAIL single_early: got out_valid before latency, expected 0"); end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_tag !== 8'h11) begin
            fails++; $display("FAIL single_head: got valid %0b tag %0h, expected 1 tag 11", out_valid, out_tag);
        end
        tests_run++;
        if (out_data !== gen(c0 + LAT)) begin
            fails++; $display("FAIL single_data: got %0h, expected %0h", out_data, gen(c0 + LAT));
        end
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL single_idle: got busy %0b valid %0b, expected 0 0", busy, out_valid);
        end
        step();
    endtask

    task automatic test_non_wb();
        int n0;
        int bad;
        n0 = n_out;
        bad = 0;
        out_ready = 1'b1;
        issue(1'b0, 8'h55);
        repeat (LAT + 3) begin
            @(negedge clk);
            if (inflight !== 4'd0 || out_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin fails++; $display("FAIL nowb_quiet: got %0d active cycles, expected 0", bad); end
        step();
        issue(1'b1, 8'h01);
        issue(1'b0, 8'h77);
        issue(1'b1, 8'h02);
        repeat (LAT + 4) step();
        tests_run++;
        if (n_out - n0 != 2) begin fails++; $display("FAIL nowb_count: got %0d outputs, expected 2", n_out - n0); end
        tests_run++;
        if (q.size() != 0) begin fails++; $display("FAIL nowb_pending: got %0d pending, expected 0", q.size()); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc;
        int first_block;
        int n0;
        int bad;
        acc = 0;
        first_block = -1;
        bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (issue_ready) acc++;
            else if (first_block < 0) first_block = i;
            issue(1'b1, TAG_W'(32 + i));
        end
        tests_run++;
        if (acc != DEPTH) begin fails++; $display("FAIL bp_accepted: got %0d, expected %0d", acc, DEPTH); end
        tests_run++;
        if (first_block != DEPTH) begin fails++; $display("FAIL bp_first_block: got %0d, expected %0d", first_block, DEPTH); end
        repeat (LAT) step();
        tests_run++;
        if (out_valid !== 1'b1 || out_tag !== 8'h20 || issue_ready !== 1'b0 || inflight !== 4'd0) begin
            fails++;
            $display("FAIL bp_full_state: got valid %0b tag %0h ready %0b inflight %0d, expected 1 20 0 0",
                     out_valid, out_tag, issue_ready, inflight);
        end
        repeat (3) begin
            @(negedge clk);
            if (q.size() == 0) bad++;
            else if (out_tag !== 8'h20 || out_data !== q[0].data) bad++;
        end
        tests_run++;
        if (bad != 0) begin fails++; $display("FAIL bp_head_stable: got %0d unstable cycles, expected 0", bad); end
        step();
        n0 = n_out;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (issue_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_before_pop: got %0b, expected 0", issue_ready); end
        @(negedge clk);
        tests_run++;
        if (issue_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_pop: got %0b, expected 1", issue_ready); end
        for (int k = 0; k < 30 && q.size() != 0; k++) @(negedge clk);
        step();
        out_ready = 1'b0;
        tests_run++;
        if (n_out - n0 != DEPTH) begin fails++; $display("FAIL bp_drain: got %0d outputs, expected %0d", n_out - n0, DEPTH); end
        tests_run++;
        if (ovf_err !== 1'b0) begin fails++; $display("FAIL bp_ovf: got %0b, expected 0", ovf_err); end
    endtask

    task automatic test_back_to_back();
        int n0;
        int nr;
        n0 = n_out;
        nr = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!issue_ready) nr++;
            issue(1'b1, TAG_W'(i));
        end
        repeat (LAT + 1) step();
        tests_run++;
        if (nr != 0) begin fails++; $display("FAIL b2b_stall: got %0d stalls, expected 0", nr); end
        tests_run++;
        if (n_out - n0 != 20 || out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_count: got %0d outputs valid %0b, expected 20 0", n_out - n0, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n0;
        out_ready = 1'b0;
        issue(1'b1, 8'hA0);
        issue(1'b1, 8'hA1);
        repeat (LAT) step();
        issue(1'b1, 8'hB0);
        issue(1'b1, 8'hB1);
        issue(1'b1, 8'hB2);
        tests_run++;
        if (inflight !== 4'd3 || out_valid !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre: got inflight %0d valid %0b, expected 3 1", inflight, out_valid);
        end
        #2;
        rst = 1'b0;
        q.delete();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || inflight !== 4'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_clear: got valid %0b inflight %0d busy %0b, expected 0 0 0",
                              out_valid, inflight, busy);
        end
        step();
        rst = 1'b1;
        n0 = n_out;
        out_ready = 1'b1;
        issue(1'b1, 8'hC0);
        issue(1'b1, 8'hC1);
        repeat (LAT + 3) step();
        tests_run++;
        if (n_out - n0 != 2 || q.size() != 0) begin
            fails++; $display("FAIL rstmid_after: got %0d outputs %0d pending, expected 2 0", n_out - n0, q.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int   sent;
        int   guard;
        int   n0;
        logic fired;
        sent = 0;
        guard = 0;
        n0 = n_out;
        while (sent < 20 && guard < 400) begin
            out_ready   = 1'($urandom_range(0, 1));
            issue_valid = 1'b1;
            issue_wb    = 1'b1;
            issue_tag   = TAG_W'(128 + sent);
            fired       = issue_ready;
            step();
            if (fired) sent++;
            guard++;
        end
        issue_valid = 1'b0;
        issue_wb    = 1'b0;
        tests_run++;
        if (sent != 20) begin fails++; $display("FAIL wrap_sent: got %0d, expected 20", sent); end
        out_ready = 1'b1;
        for (int k = 0; k < 40 && (q.size() != 0 || busy); k++) @(negedge clk);
        step();
        out_ready = 1'b0;
        tests_run++;
        if (n_out - n0 != 20 || q.size() != 0) begin
            fails++; $display("FAIL wrap_drain: got %0d outputs %0d pending, expected 20 0", n_out - n0, q.size());
        end
        tests_run++;
        if (ovf_err !== 1'b0) begin fails++; $display("FAIL wrap_ovf: got %0b, expected 0", ovf_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_non_wb();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
